// File: rtl/mlvds_transceiver_model.sv
`default_nettype none
// ============================================================================
// Module   : mlvds_transceiver_model
// Brief    : Clocked N-channel M-LVDS transceiver bench model with delays,
//            turnaround-guarded direction FSM, contention and fail-safe RX.
// Revision : 1.0
// ============================================================================
module mlvds_transceiver_model #(
    parameter int G_SIZE     = 8,
    parameter int MAX_DELAY  = 16,
    parameter int TURNAROUND = 4,
    parameter int CNT_W      = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    inout  wire  [G_SIZE-1:0]            P,
    inout  wire  [G_SIZE-1:0]            N,
    input  logic [G_SIZE-1:0]            D,
    input  logic [G_SIZE-1:0]            DE,
    input  logic                         REn,
    output logic [G_SIZE-1:0]            R,
    input  logic [$clog2(MAX_DELAY)-1:0] cmos2lvds_delay,
    input  logic [$clog2(MAX_DELAY)-1:0] lvds2cmos_delay,
    output logic [G_SIZE-1:0]            tx_active,
    output logic [G_SIZE-1:0]            contention,
    output logic [CNT_W-1:0]             contention_cnt
);

    localparam int c_DW  = $clog2(MAX_DELAY);
    localparam int c_CW  = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
    localparam int c_PW  = $clog2(G_SIZE + 1);
    localparam int c_SW  = ((CNT_W > c_PW) ? CNT_W : c_PW) + 1;

    localparam logic [c_DW-1:0]  c_DLY_MAX = c_DW'(MAX_DELAY - 1);
    localparam logic [c_CW-1:0]  c_GUARD   = c_CW'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    localparam logic [1:0] c_RX    = 2'd0;
    localparam logic [1:0] c_RX2TX = 2'd1;
    localparam logic [1:0] c_TX    = 2'd2;
    localparam logic [1:0] c_TX2RX = 2'd3;

    logic [c_DW-1:0]   r_tx_dly;
    logic [c_DW-1:0]   r_rx_dly;
    logic [G_SIZE-1:0] r_contention;
    logic [CNT_W-1:0]  r_cnt;
    logic [G_SIZE-1:0] w_cont;
    logic [G_SIZE-1:0] w_rx_tap;
    logic [c_SW-1:0]   w_ncont;
    logic [c_SW-1:0]   w_sum;
    logic [CNT_W-1:0]  w_cnt_next;

    // Delays are registered so a change lands on the next clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_dly <= '0;
            r_rx_dly <= '0;
        end else begin
            r_tx_dly <= (cmos2lvds_delay > c_DLY_MAX) ? c_DLY_MAX : cmos2lvds_delay;
            r_rx_dly <= (lvds2cmos_delay > c_DLY_MAX) ? c_DLY_MAX : lvds2cmos_delay;
        end
    end

    generate
        for (genvar gi = 0; gi < G_SIZE; gi++) begin : g_ch
            logic [1:0]           r_state;
            logic [c_CW-1:0]      r_guard;
            logic [MAX_DELAY-1:0] r_tx_sr;
            logic [MAX_DELAY-1:0] r_rx_sr;
            logic                 w_tx_bit;
            logic                 w_rx_bit;

            assign w_tx_bit      = r_tx_sr[r_tx_dly];
            assign tx_active[gi] = (r_state == c_TX);
            assign P[gi]         = tx_active[gi] ? w_tx_bit  : 1'bz;
            assign N[gi]         = tx_active[gi] ? ~w_tx_bit : 1'bz;
            // Anything other than a clean differential pair resolves low.
            assign w_rx_bit      = (P[gi] === 1'b1) && (N[gi] === 1'b0);
            assign w_rx_tap[gi]  = r_rx_sr[r_rx_dly];
            assign w_cont[gi]    = tx_active[gi] &&
                                   ((P[gi] !== w_tx_bit) || (N[gi] !== ~w_tx_bit));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state <= c_RX;
                    r_guard <= '0;
                    r_tx_sr <= '0;
                    r_rx_sr <= '0;
                end else begin
                    r_tx_sr <= {r_tx_sr[MAX_DELAY-2:0], D[gi]};
                    r_rx_sr <= {r_rx_sr[MAX_DELAY-2:0], w_rx_bit};
                    case (r_state)
                        c_RX: begin
                            if (DE[gi]) begin
                                r_state <= c_RX2TX;
                                r_guard <= c_GUARD;
                            end
                        end
                        c_RX2TX: begin
                            if (!DE[gi])
                                r_state <= c_RX;
                            else if (r_guard == '0)
                                r_state <= c_TX;
                            else
                                r_guard <= r_guard - 1'b1;
                        end
                        c_TX: begin
                            if (!DE[gi]) begin
                                r_state <= c_TX2RX;
                                r_guard <= c_GUARD;
                            end
                        end
                        c_TX2RX: begin
                            if (r_guard == '0)
                                r_state <= c_RX;
                            else
                                r_guard <= r_guard - 1'b1;
                        end
                        default: r_state <= c_RX;
                    endcase
                end
            end
        end
    endgenerate

    always_comb begin
        w_ncont = '0;
        for (int k = 0; k < G_SIZE; k++) begin
            w_ncont = w_ncont + c_SW'(w_cont[k]);
        end
        w_sum      = c_SW'(r_cnt) + w_ncont;
        w_cnt_next = (w_sum > c_SW'(c_CNT_MAX)) ? c_CNT_MAX : w_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_contention <= '0;
            r_cnt        <= '0;
        end else begin
            r_contention <= r_contention | w_cont;
            r_cnt        <= w_cnt_next;
        end
    end

    assign contention     = r_contention;
    assign contention_cnt = r_cnt;
    assign R              = REn ? {G_SIZE{1'bz}} : w_rx_tap;

endmodule
`default_nettype wire

// File: tb/tb_mlvds_transceiver_model.sv
`default_nettype none
// ============================================================================
// Module   : tb_mlvds_transceiver_model
// Brief    : Directed self-checking bench for mlvds_transceiver_model.
// Revision : 1.0
// ============================================================================
module tb_mlvds_transceiver_model;

    localparam int c_G    = 8;
    localparam int c_MAXD = 16;
    localparam int c_TA   = 4;
    localparam int c_CW   = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    wire  [c_G-1:0]    P;
    wire  [c_G-1:0]    N;
    logic [c_G-1:0]    D;
    logic [c_G-1:0]    DE;
    logic              REn;
    wire  [c_G-1:0]    R;
    logic [3:0]        tx_dly;
    logic [3:0]        rx_dly;
    wire  [c_G-1:0]    tx_active;
    wire  [c_G-1:0]    contention;
    wire  [c_CW-1:0]   contention_cnt;

    logic [c_G-1:0]    ext_en;
    logic [c_G-1:0]    ext_p;
    logic [c_G-1:0]    ext_n;

    int n_tests = 0;
    int n_fail  = 0;
    int seen;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < c_G; gi++) begin : g_ext
            assign P[gi] = ext_en[gi] ? ext_p[gi] : 1'bz;
            assign N[gi] = ext_en[gi] ? ext_n[gi] : 1'bz;
        end
    endgenerate

    mlvds_transceiver_model #(
        .G_SIZE     (c_G),
        .MAX_DELAY  (c_MAXD),
        .TURNAROUND (c_TA),
        .CNT_W      (c_CW)
    ) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .P               (P),
        .N               (N),
        .D               (D),
        .DE              (DE),
        .REn             (REn),
        .R               (R),
        .cmos2lvds_delay (tx_dly),
        .lvds2cmos_delay (rx_dly),
        .tx_active       (tx_active),
        .contention      (contention),
        .contention_cnt  (contention_cnt)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bit set where the pair carries a clean differential level.
    function automatic logic [c_G-1:0] driven_mask(input logic [c_G-1:0] p, input logic [c_G-1:0] n);
        logic [c_G-1:0] m;
        for (int i = 0; i < c_G; i++) begin
            m[i] = ((p[i] === 1'b1) && (n[i] === 1'b0)) || ((p[i] === 1'b0) && (n[i] === 1'b1));
        end
        return m;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        D      = '0;
        DE     = '0;
        REn    = 1'b0;
        tx_dly = 4'd0;
        rx_dly = 4'd0;
        ext_en = '0;
        ext_p  = '0;
        ext_n  = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_released", 32'(driven_mask(P, N)), 32'h0);
        chk("rst_R",        32'(R),                 32'h0);
        chk("rst_tx_active",32'(tx_active),         32'h0);
        chk("rst_cont",     32'(contention),        32'h0);
        chk("rst_cnt",      32'(contention_cnt),    32'h0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_tx_active", 32'(tx_active), 32'h0);

        // RX->TX guard and TX latency on channel 0
        tx_dly = 4'd3;
        DE[0]  = 1'b1;
        repeat (4) tick();
        chk("guard_still_off", 32'(tx_active[0]), 32'h0);
        tick();
        chk("guard_tx_on", 32'(tx_active[0]), 32'h1);
        chk("tx_p0_low",   32'(P[0]), 32'h0);
        chk("tx_n0_high",  32'(N[0]), 32'h1);
        D[0] = 1'b1;
        repeat (3) tick();
        chk("tx_lat_early", 32'(P[0]), 32'h0);
        tick();
        chk("tx_lat_p", 32'(P[0]), 32'h1);
        chk("tx_lat_n", 32'(N[0]), 32'h0);
        tick();
        chk("loopback_R0", 32'(R[0]), 32'h1);

        // External driver on channel 2, RX delays 0 and 5
        ext_en[2] = 1'b1; ext_p[2] = 1'b1; ext_n[2] = 1'b0;
        chk("rx0_before", 32'(R[2]), 32'h0);
        tick();
        chk("rx0_follow", 32'(R[2]), 32'h1);
        ext_en[2] = 1'b0;
        tick();
        chk("rx0_failsafe", 32'(R[2]), 32'h0);
        rx_dly = 4'd5;
        repeat (16) tick();
        ext_en[2] = 1'b1;
        repeat (5) tick();
        chk("rx5_early", 32'(R[2]), 32'h0);
        tick();
        chk("rx5_follow", 32'(R[2]), 32'h1);
        ext_en[2] = 1'b0;
        repeat (5) tick();
        chk("rx5_hold", 32'(R[2]), 32'h1);
        tick();
        chk("rx5_failsafe", 32'(R[2]), 32'h0);
        rx_dly = 4'd0;

        // Contention on channel 1 for 10 cycles
        D[1]  = 1'b1;
        DE[1] = 1'b1;
        repeat (6) tick();
        chk("ch1_tx",       32'(tx_active[1]), 32'h1);
        chk("ch1_no_cont",  32'(contention),   32'h0);
        ext_en[1] = 1'b1; ext_p[1] = 1'b0; ext_n[1] = 1'b1;
        repeat (10) tick();
        ext_en[1] = 1'b0;
        chk("cont_flag", 32'(contention),     32'h02);
        chk("cont_cnt",  32'(contention_cnt), 32'd10);
        repeat (3) tick();
        chk("cont_sticky",    32'(contention),     32'h02);
        chk("cont_cnt_hold",  32'(contention_cnt), 32'd10);

        // RX2TX abort on channel 3
        DE[3] = 1'b1;
        tick();
        tick();
        DE[3] = 1'b0;
        seen = 0;
        repeat (8) begin
            tick();
            seen += int'(tx_active[3]);
        end
        chk("abort_no_drive", 32'(seen), 32'd0);

        // DE re-asserted during TX2RX on channel 4
        DE[4] = 1'b1;
        repeat (6) tick();
        chk("ch4_tx", 32'(tx_active[4]), 32'h1);
        DE[4] = 1'b0;
        tick();
        chk("ch4_tx2rx", 32'(tx_active[4]), 32'h0);
        DE[4] = 1'b1;
        seen = 0;
        repeat (8) begin
            tick();
            seen += int'(!tx_active[4]);
        end
        chk("ch4_guard_low", 32'(seen), 32'd8);
        tick();
        chk("ch4_reenter", 32'(tx_active[4]), 32'h1);

        // All channels in TX, then asynchronous reset
        D  = 8'hA5;
        DE = 8'hFF;
        repeat (20) tick();
        chk("all_tx",     32'(tx_active), 32'hFF);
        chk("all_p",      32'(P),         32'hA5);
        chk("all_n",      32'(N),         32'h5A);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_released", 32'(driven_mask(P, N)), 32'h0);
        chk("arst_tx",       32'(tx_active),          32'h0);
        chk("arst_cont",     32'(contention),         32'h0);
        chk("arst_cnt",      32'(contention_cnt),     32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Saturation of the 4-bit counter with four contending channels
        repeat (20) tick();
        chk("sat_pre_tx",  32'(tx_active),      32'hFF);
        chk("sat_pre_cnt", 32'(contention_cnt), 32'd0);
        ext_en = 8'hF0; ext_p = ~D; ext_n = D;
        tick();
        chk("sat_cnt_4", 32'(contention_cnt), 32'd4);
        tick();
        chk("sat_cnt_8", 32'(contention_cnt), 32'd8);
        tick();
        chk("sat_cnt_12", 32'(contention_cnt), 32'd12);
        tick();
        chk("sat_cnt_15", 32'(contention_cnt), 32'd15);
        tick();
        chk("sat_cnt_hold", 32'(contention_cnt), 32'd15);
        chk("sat_flags",    32'(contention),     32'hF0);
        ext_en = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
